// File: rtl/fifo_axis_drain.sv
// Drain stage: pulls PKT_LEN words from a registered-read FIFO and replays
// them as an AXI-Stream packet through a 2-entry skid buffer.
module fifo_axis_drain #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PKT_LEN    = 16
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic                  START,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  FIFO_RD_CMD,
  input  logic [DATA_WIDTH-1:0] FIFO_RD_DATA,
  input  logic                  FIFO_EMPTY,
  output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                  M_AXIS_TVALID,
  input  logic                  M_AXIS_TREADY,
  output logic                  M_AXIS_TLAST
);

  localparam int unsigned CW = $clog2(PKT_LEN + 1);
  localparam logic [CW-1:0] LP_LEN  = CW'(PKT_LEN);
  localparam logic [CW-1:0] LP_LAST = CW'(PKT_LEN - 1);
  localparam logic [CW-1:0] LP_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CW-1:0]         r_rd_issued;
  logic [CW-1:0]         r_beat;
  logic                  r_inflight;
  logic [DATA_WIDTH-1:0] r_buf [2];
  logic                  r_head;
  logic                  r_tail;
  logic [1:0]            r_occ;

  logic                  w_rd_cmd;
  logic                  w_pop;
  logic                  w_valid;
  logic                  w_last;
  logic                  w_done;
  logic                  w_start;
  logic [2:0]            w_pending;

  // Words already committed to the buffer: stored plus the one arriving now.
  assign w_pending = {1'b0, r_occ} + {2'b00, r_inflight};

  // Next-state, read credit and stream handshake decode.
  always_comb begin
    w_state_nxt = r_state;
    w_valid     = (r_occ != 2'd0);
    w_pop       = w_valid && M_AXIS_TREADY;
    w_last      = w_valid && (r_beat == LP_LAST);
    w_start     = (r_state == S_IDLE) && START;
    w_rd_cmd    = (r_state == S_RUN) && !FIFO_EMPTY &&
                  (r_rd_issued < LP_LEN) && (w_pending < 3'd2);
    w_done      = (r_state == S_DRAIN) && w_pop && w_last;
    unique case (r_state)
      S_IDLE:  if (START) w_state_nxt = S_RUN;
      S_RUN:   if (w_rd_cmd && (r_rd_issued == LP_LAST)) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Read-issue and beat counters plus the read-latency tracker.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_rd_issued <= '0;
      r_beat      <= '0;
      r_inflight  <= 1'b0;
    end else begin
      r_inflight <= w_rd_cmd;
      if (w_start)       r_rd_issued <= '0;
      else if (w_rd_cmd) r_rd_issued <= r_rd_issued + LP_ONE;
      if (w_done)        r_beat <= '0;
      else if (w_pop)    r_beat <= r_beat + LP_ONE;
    end
  end

  // Two-entry ring buffer: returning FIFO data is always accepted at the tail.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      for (int unsigned i = 0; i < 2; i++) r_buf[i] <= '0;
      r_head <= 1'b0;
      r_tail <= 1'b0;
      r_occ  <= 2'd0;
    end else begin
      if (r_inflight) begin
        r_buf[r_tail] <= FIFO_RD_DATA;
        r_tail        <= ~r_tail;
      end
      if (w_pop) r_head <= ~r_head;
      unique case ({r_inflight, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // The read credit rule must keep a returning word from landing on a full buffer.
  always_ff @(posedge CLK) begin
    if (RESETN && r_inflight) assert (r_occ != 2'd2);
  end

  assign BUSY          = (r_state != S_IDLE);
  assign DONE          = w_done;
  assign FIFO_RD_CMD   = w_rd_cmd;
  assign M_AXIS_TDATA  = r_buf[r_head];
  assign M_AXIS_TVALID = w_valid;
  assign M_AXIS_TLAST  = w_last;

endmodule

// File: tb/tb_fifo_axis_drain.sv
// Bench for fifo_axis_drain: behavioural FIFO, stream-order model, directed steps.
module tb_fifo_axis_drain;

  localparam int DW = 32;
  localparam int PL = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, rd_cmd, empty, tvalid, tlast;
  logic          tready = 1'b0;
  logic [DW-1:0] rd_data, tdata;

  logic          start1 = 1'b0, empty1 = 1'b1, tready1 = 1'b0;
  logic          busy1, done1, rd_cmd1, tvalid1, tlast1;
  logic [DW-1:0] rd_data1 = '0, tdata1;

  logic          wr_req = 1'b0;
  logic [DW-1:0] wr_val = '0;
  logic [DW-1:0] fq [$];

  int checks = 0, failures = 0;

  // model state
  logic [DW-1:0] exp_q [$];
  bit            m_busy = 0;
  int            m_beat = 0, m_pulled = 0, m_hs = 0, done_cnt = 0;
  bit            prev_stall = 0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;
  int            step_no = 0, first_cmd = -1, first_valid = -1;

  always #5 clk = ~clk;

  fifo_axis_drain #(.DATA_WIDTH(DW), .PKT_LEN(PL)) u_dut (
    .CLK(clk), .RESETN(rst_n), .START(start), .BUSY(busy), .DONE(done),
    .FIFO_RD_CMD(rd_cmd), .FIFO_RD_DATA(rd_data), .FIFO_EMPTY(empty),
    .M_AXIS_TDATA(tdata), .M_AXIS_TVALID(tvalid), .M_AXIS_TREADY(tready),
    .M_AXIS_TLAST(tlast)
  );

  fifo_axis_drain #(.DATA_WIDTH(DW), .PKT_LEN(1)) u_dut1 (
    .CLK(clk), .RESETN(rst_n), .START(start1), .BUSY(busy1), .DONE(done1),
    .FIFO_RD_CMD(rd_cmd1), .FIFO_RD_DATA(rd_data1), .FIFO_EMPTY(empty1),
    .M_AXIS_TDATA(tdata1), .M_AXIS_TVALID(tvalid1), .M_AXIS_TREADY(tready1),
    .M_AXIS_TLAST(tlast1)
  );

  // Behavioural FIFO with 1-cycle registered read and registered empty flag.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fq.delete();
      rd_data <= '0;
      empty   <= 1'b1;
    end else begin
      if (rd_cmd && fq.size() > 0) rd_data <= fq.pop_front();
      if (wr_req) fq.push_back(wr_val);
      empty <= (fq.size() == 0);
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check_eq({tag, "_busy"},   busy,   0);
    check_eq({tag, "_done"},   done,   0);
    check_eq({tag, "_rdcmd"},  rd_cmd, 0);
    check_eq({tag, "_tvalid"}, tvalid, 0);
    check_eq({tag, "_tlast"},  tlast,  0);
    check_eq({tag, "_tdata"},  tdata,  0);
  endtask

  // Per-cycle comparison of the main DUT against the stream model.
  task automatic check_cycle();
    bit hs, exp_done, exp_last;
    logic [DW-1:0] ew;
    step_no++;
    check_eq("busy", busy, m_busy);
    if (!m_busy) check_eq("idle_tvalid", tvalid, 0);
    if (rd_cmd === 1'b1) begin
      if (first_cmd < 0) first_cmd = step_no;
      m_pulled++;
      check_eq("rd_when_empty", empty, 0);
      check_eq("rd_outstanding_le2", (m_pulled - m_hs) <= 2, 1);
      check_eq("rd_count_le_len", m_pulled <= PL, 1);
    end
    if (prev_stall) begin
      check_eq("hold_tvalid", tvalid, 1);
      check_eq("hold_tdata",  tdata,  prev_data);
      check_eq("hold_tlast",  tlast,  prev_last);
    end
    if (tvalid === 1'b1 && first_valid < 0) first_valid = step_no;
    exp_last = m_busy && (tvalid === 1'b1) && (m_beat == PL - 1);
    hs       = m_busy && (tvalid === 1'b1) && (tready === 1'b1);
    exp_done = hs && (m_beat == PL - 1);
    check_eq("tlast", tlast, exp_last);
    check_eq("done",  done,  exp_done);
    if (hs) begin
      check_eq("exp_available", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        ew = exp_q.pop_front();
        check_eq("tdata", tdata, ew);
      end
      m_hs++;
      m_beat++;
    end
    if (done === 1'b1) done_cnt++;
    prev_stall = (tvalid === 1'b1) && (tready !== 1'b1);
    prev_data  = tdata;
    prev_last  = tlast;
    if (exp_done) m_busy = 0;
    else if (!m_busy && start) begin
      m_busy = 1; m_beat = 0; m_pulled = 0; m_hs = 0;
    end
  endtask

  // One clock: drive inputs after the falling edge, then sample and check.
  task automatic step(input bit st, input bit wr, input logic [DW-1:0] wv,
                      input bit rdy, input bit start_on_last);
    @(negedge clk);
    start  = st;
    if (start_on_last && tvalid === 1'b1 && tlast === 1'b1) start = 1'b1;
    wr_req = wr;
    wr_val = wv;
    tready = rdy;
    if (wr) exp_q.push_back(wv);
    #1;
    check_cycle();
  endtask

  task automatic preload(input int n);
    for (int i = 0; i < n; i++) step(0, 1, $urandom, 0, 0);
    step(0, 0, '0, 0, 0);
  endtask

  // mode: 0 ready always, 1 toggling, 2 random. Returns when idle or after stop_hs beats.
  task automatic run_pkt(input int mode, input int feed, input bit repulse, input int stop_hs);
    int fed = 0;
    bit rdy, wr;
    for (int c = 0; c < 800; c++) begin
      if (!m_busy) return;
      if (stop_hs > 0 && m_hs >= stop_hs) return;
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? ((c % 2) == 0) : 1'($urandom_range(0, 1));
      wr  = (fed < feed) && ((c % 4) == 0);
      if (wr) fed++;
      step(repulse && (c == 3), wr, $urandom, rdy, repulse);
    end
    check_eq("pkt_timeout_busy", busy, 0);
  endtask

  task automatic do_packet(input string tag, input int mode, input int feed, input bit repulse);
    int d0 = done_cnt;
    step(1, 0, '0, 0, 0);
    run_pkt(mode, feed, repulse, 0);
    step(0, 0, '0, 1, 0);
    check_eq({tag, "_done_count"}, done_cnt - d0, 1);
    check_eq({tag, "_beats"}, m_hs, PL);
  endtask

  initial begin
    // reset state
    step(0, 0, '0, 0, 0);
    step(0, 0, '0, 0, 0);
    check_reset_outs("reset");
    check_eq("reset1_busy", busy1, 0);
    check_eq("reset1_tvalid", tvalid1, 0);
    check_eq("reset1_tlast", tlast1, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: preloaded, ready always high
    preload(PL);
    first_cmd = -1; first_valid = -1;
    do_packet("t1", 0, 0, 0);
    check_eq("t1_valid_latency", first_valid - first_cmd, 2);
    check_eq("t1_leftover", exp_q.size(), 0);

    // 2: ready toggling
    preload(PL);
    do_packet("t2", 1, 0, 0);
    check_eq("t2_leftover", exp_q.size(), 0);

    // 3: FIFO empty at start, one word every 4 cycles
    do_packet("t3", 0, PL, 0);
    check_eq("t3_leftover", exp_q.size(), 0);

    // 4: extra START pulses in RUN and on the DONE cycle, then a fresh packet
    preload(2 * PL);
    do_packet("t4a", 2, 0, 1);
    check_eq("t4_remaining", exp_q.size(), PL);
    do_packet("t4b", 0, 0, 0);
    check_eq("t4_leftover", exp_q.size(), 0);

    // 5: asynchronous reset after the 7th beat
    preload(PL);
    step(1, 0, '0, 0, 0);
    run_pkt(2, 0, 0, 7);
    check_eq("t5_beats_before_reset", m_hs, 7);
    #2 rst_n = 1'b0;
    #1 check_reset_outs("t5_async");
    exp_q.delete();
    m_busy = 0; prev_stall = 0;
    step(0, 0, '0, 0, 0);
    step(0, 0, '0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    preload(PL);
    do_packet("t5b", 2, 0, 0);
    check_eq("t5_leftover", exp_q.size(), 0);

    // 6: PKT_LEN=1 instance
    rd_data1 = 32'hC0FF_EE01;
    empty1   = 1'b0;
    tready1  = 1'b0;
    start1   = 1'b1;
    step(0, 0, '0, 0, 0);
    start1 = 1'b0;
    check_eq("t6_busy_run", busy1, 1);
    check_eq("t6_rdcmd_run", rd_cmd1, 1);
    step(0, 0, '0, 0, 0);
    check_eq("t6_rdcmd_drain", rd_cmd1, 0);
    check_eq("t6_tvalid_early", tvalid1, 0);
    step(0, 0, '0, 0, 0);
    check_eq("t6_tvalid", tvalid1, 1);
    check_eq("t6_tlast", tlast1, 1);
    check_eq("t6_tdata", tdata1, 32'hC0FF_EE01);
    check_eq("t6_done_stalled", done1, 0);
    tready1 = 1'b1;
    #1 check_eq("t6_done", done1, 1);
    step(0, 0, '0, 0, 0);
    check_eq("t6_busy_after", busy1, 0);
    check_eq("t6_tvalid_after", tvalid1, 0);
    check_eq("t6_rdcmd_idle", rd_cmd1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
